// File: rtl/sram_slice_arbiter_pkg.sv
// sram_slice_arbiter_pkg: slot position constants and requester encoding shared by the arbiter slice
package sram_slice_arbiter_pkg;
    localparam logic [2:0] VID_FIRST = 3'd0;
    localparam logic [2:0] ACC_FIRST = 3'd4;
    localparam logic [1:0] WE_START  = 2'd1;
    localparam logic [1:0] WE_END    = 2'd2;
    localparam logic [1:0] ACK_K     = 2'd3;
    typedef enum logic [1:0] {NONE = 2'd0, CPU = 2'd1, DMA = 2'd2} req_e;
endpackage

// File: rtl/sram_slice_arbiter_slice_timer.sv
// slice_timer: 5-bit phase counter with registered clock-enable and slot decode
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   fetch_en_i         framebuffer ownership of lower slots, sampled at each s=0 boundary
//   nxt_k_o            slot-relative position of the next cycle
//   nxt_start_o        next cycle is the first cycle of a slot
//   nxt_vid_o          next cycle belongs to a video slot
//   ce12_o, ce6_o, ce6x_o, pipe_ab_o, video_slice_o   registered enables aligned to the current phase
module slice_timer
    import sram_slice_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       fetch_en_i,
    output logic [1:0] nxt_k_o,
    output logic       nxt_start_o,
    output logic       nxt_vid_o,
    output logic       ce12_o,
    output logic       ce6_o,
    output logic       ce6x_o,
    output logic       pipe_ab_o,
    output logic       video_slice_o
);
    logic [4:0] ph_q, ph_d;
    logic       fetch_q, fetch_d;

    // Everything is decoded from the next phase so registered outputs line up with ph_q.
    always_comb begin
        ph_d    = ph_q + 5'd1;
        fetch_d = (ph_d[2:0] == VID_FIRST) ? fetch_en_i : fetch_q;
    end

    assign nxt_k_o     = ph_d[1:0];
    assign nxt_start_o = ph_d[1:0] == 2'd0;
    assign nxt_vid_o   = fetch_d && (ph_d[2:0] < ACC_FIRST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ph_q          <= 5'd0;
            fetch_q       <= 1'b0;
            ce12_o        <= 1'b0;
            ce6_o         <= 1'b0;
            ce6x_o        <= 1'b0;
            pipe_ab_o     <= 1'b0;
            video_slice_o <= 1'b0;
        end else begin
            ph_q          <= ph_d;
            fetch_q       <= fetch_d;
            ce12_o        <= ph_d[0];
            ce6_o         <= ph_d[1:0] == 2'b11;
            ce6x_o        <= ph_d[1:0] == 2'b01;
            pipe_ab_o     <= ph_d[3];
            video_slice_o <= nxt_vid_o;
        end
    end
endmodule

// File: rtl/sram_slice_arbiter.sv
// sram_slice_arbiter: time-slice scheduler sharing one 8-bit SRAM between video fetch, CPU and DMA
// Ports:
//   clk24, reset                      24 MHz clock, synchronous active-high reset
//   fetch_en, video_addr              framebuffer slot ownership and fetch address
//   cpu_req/we/addr/wdata, cpu_ack    CPU req/ack port, ack is a one-cycle pulse
//   dma_req/we/addr/wdata, dma_ack    DMA req/ack port, ack is a one-cycle pulse
//   rdata                             data of the last completed CPU/DMA read
//   sram_addr/dout/din/dq_oe/we_n/oe_n  SRAM pins
//   ce12, ce6, ce6x, video_slice, pipe_ab  clock enables and video strobes
// The first lower slot after reset is idle because its slot start coincided with reset.
module sram_slice_arbiter
    import sram_slice_arbiter_pkg::*;
#(
    parameter logic [1:0] STARVE_MAX = 2'd3
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic [15:0] video_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  rdata,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_dout,
    input  logic [7:0]  sram_din,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        ce12,
    output logic        ce6,
    output logic        ce6x,
    output logic        video_slice,
    output logic        pipe_ab
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] VID    = 2'd1;
    localparam logic [1:0] ACC_RD = 2'd2;
    localparam logic [1:0] ACC_WR = 2'd3;

    logic [1:0]  nk;
    logic        nstart, nvid;
    logic [1:0]  state_q, state_d, starve_q, starve_d;
    req_e        who_q, who_d;
    logic        dma_win, any_req, sel_we;
    logic [15:0] sel_addr, addr_q, addr_d;
    logic [7:0]  sel_wdata, dout_q, dout_d, rdata_q, rdata_d;
    logic        oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
    logic        cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;

    slice_timer u_timer (
        .clk_i         (clk24),
        .rst_i         (reset),
        .fetch_en_i    (fetch_en),
        .nxt_k_o       (nk),
        .nxt_start_o   (nstart),
        .nxt_vid_o     (nvid),
        .ce12_o        (ce12),
        .ce6_o         (ce6),
        .ce6x_o        (ce6x),
        .pipe_ab_o     (pipe_ab),
        .video_slice_o (video_slice)
    );

    // Requests are sampled on the edge that enters k=0, so the slot's strobes are already valid at k=0.
    always_comb begin
        any_req   = cpu_req || dma_req;
        dma_win   = dma_req && (!cpu_req || starve_q == STARVE_MAX);
        sel_addr  = dma_win ? dma_addr : cpu_addr;
        sel_we    = dma_win ? dma_we : cpu_we;
        sel_wdata = dma_win ? dma_wdata : cpu_wdata;
        state_d   = state_q;
        who_d     = who_q;
        starve_d  = starve_q;
        if (nstart) begin
            state_d = nvid ? VID : !any_req ? IDLE : sel_we ? ACC_WR : ACC_RD;
            who_d   = (nvid || !any_req) ? NONE : dma_win ? DMA : CPU;
            if (!nvid && dma_req)
                starve_d = dma_win ? 2'd0 : (starve_q == 2'd3) ? starve_q : starve_q + 2'd1;
        end
        addr_d    = (state_d == VID) ? video_addr : (nstart && state_d[1]) ? sel_addr : addr_q;
        dout_d    = (nstart && state_d == ACC_WR) ? sel_wdata : dout_q;
        oe_n_d    = !(state_d == VID || state_d == ACC_RD);
        we_n_d    = !(state_d == ACC_WR && nk >= WE_START && nk <= WE_END);
        dq_oe_d   = state_d == ACC_WR;
        cpu_ack_d = state_d[1] && nk == ACK_K && who_d == CPU;
        dma_ack_d = state_d[1] && nk == ACK_K && who_d == DMA;
        rdata_d   = (state_d == ACC_RD && nk == ACK_K) ? sram_din : rdata_q;
    end

    always_ff @(posedge clk24) begin
        if (reset) begin
            state_q   <= IDLE;
            who_q     <= NONE;
            starve_q  <= 2'd0;
            addr_q    <= 16'd0;
            dout_q    <= 8'd0;
            rdata_q   <= 8'd0;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            who_q     <= who_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rdata_q   <= rdata_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            dq_oe_q   <= dq_oe_d;
            cpu_ack_q <= cpu_ack_d;
            dma_ack_q <= dma_ack_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_dout  = dout_q;
    assign rdata      = rdata_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_dq_oe = dq_oe_q;
    assign cpu_ack    = cpu_ack_q;
    assign dma_ack    = dma_ack_q;
endmodule

// File: tb/tb_sram_slice_arbiter.sv
// tb_sram_slice_arbiter: scoreboard bench for the SRAM time-slice arbiter
module tb_sram_slice_arbiter;
    logic        clk24 = 1'b0, reset = 1'b1, fetch_en = 1'b1;
    logic [15:0] video_addr = 16'hBEEF;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] cpu_addr = 16'd0, dma_addr = 16'd0;
    logic [7:0]  cpu_wdata = 8'd0, dma_wdata = 8'd0, sram_din = 8'd0;
    logic        cpu_ack, dma_ack, sram_dq_oe, sram_we_n, sram_oe_n;
    logic        ce12, ce6, ce6x, video_slice, pipe_ab;
    logic [7:0]  rdata, sram_dout;
    logic [15:0] sram_addr;
    logic [4:0]  mph = 5'd0;
    int          tests = 0, fails = 0;

    typedef struct { int who; int ph; int addr; bit rd; int rdata; } exp_t;
    exp_t exp_q[$];

    sram_slice_arbiter dut (
        .clk24(clk24), .reset(reset), .fetch_en(fetch_en), .video_addr(video_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .rdata(rdata), .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .ce12(ce12), .ce6(ce6), .ce6x(ce6x), .video_slice(video_slice), .pipe_ab(pipe_ab)
    );

    always #5 clk24 = ~clk24;

    // Reference phase: 0 in every cycle following a sampled reset, else counts modulo 32.
    always @(posedge clk24) mph <= reset ? 5'd0 : mph + 5'd1;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at ph %0d", name, act, req, mph);
        end
    endtask

    task automatic push(input int who, input int ph, input int addr, input bit rd, input int rd_val);
        exp_t e;
        e.who = who; e.ph = ph; e.addr = addr; e.rd = rd; e.rdata = rd_val;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack must match the oldest expected completion.
    always @(negedge clk24) begin
        exp_t e;
        if (cpu_ack || dma_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {dma_ack, cpu_ack}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_who", {dma_ack, cpu_ack}, e.who);
                chk("ack_ph", mph, e.ph);
                chk("ack_addr", sram_addr, e.addr);
                if (e.rd) chk("ack_rdata", rdata, e.rdata);
            end
        end
    end

    task automatic wait_ph(input int p);
        int n = 0;
        do begin
            @(negedge clk24);
            n++;
        end while (int'(mph) != p && n < 64);
        if (int'(mph) != p) chk("wait_ph_timeout", mph, p);
    endtask

    task automatic do_reset();
        @(negedge clk24);
        reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; fetch_en = 1'b1;
        repeat (2) @(negedge clk24);
        chk("reset_strobes", {ce12, ce6, ce6x, video_slice, pipe_ab, sram_we_n, sram_oe_n, sram_dq_oe, cpu_ack, dma_ack},
            10'b00000_11000);
        chk("reset_data", {rdata, sram_addr, sram_dout}, 0);
        reset = 1'b0;
    endtask

    task automatic wait_cpu_ack(input string name);
        int n = 0;
        do begin
            @(negedge clk24);
            n++;
        end while (!cpu_ack && n < 40);
        if (!cpu_ack) chk(name, 0, 1);
        cpu_req = 1'b0;
    endtask

    initial begin
        int nd, na;
        bit past8;
        // Idle frame: enables, video strobes, no acks.
        do_reset();
        wait_ph(31);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] p;
            @(negedge clk24);
            p = mph;
            chk("idle_frame", {ce12, ce6, ce6x, pipe_ab, video_slice, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, dma_ack},
                {p[0], p[1:0] == 2'b11, p[1:0] == 2'b01, p[3], !p[2], p[2], 1'b1, 1'b0, 1'b0, 1'b0});
        end
        // CPU read of 0x1234 issued at ph 2.
        do_reset();
        wait_ph(2);
        sram_din = 8'h5C;
        push(1, 7, 16'h1234, 1'b1, 8'h5C);
        cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
        wait_cpu_ack("cpu_rd_timeout");
        // CPU write 0xA5 to 0x8000, then a video slot at ph 8.
        do_reset();
        wait_ph(2);
        push(1, 7, 16'h8000, 1'b0, 0);
        cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'hA5; cpu_req = 1'b1;
        for (int p = 3; p <= 8; p++) begin
            @(negedge clk24);
            chk("wr_we_n", sram_we_n, (p == 5 || p == 6) ? 0 : 1);
            chk("wr_dq_oe", sram_dq_oe, (p >= 4 && p <= 7) ? 1 : 0);
            if (p >= 4 && p <= 7) chk("wr_dout", sram_dout, 8'hA5);
            if (p == 7) cpu_req = 1'b0;
            if (p == 8) chk("vid_after_wr", {sram_oe_n, sram_addr}, {1'b0, video_addr});
        end
        // CPU and DMA both held: CPU, CPU, CPU, DMA, repeated.
        do_reset();
        wait_ph(2);
        sram_din = 8'h77;
        for (int i = 0; i < 8; i++)
            push((i % 4 == 3) ? 2 : 1, 7 + 8 * (i % 4), (i % 4 == 3) ? 16'h3000 : 16'h2000, 1'b1, 8'h77);
        cpu_we = 1'b0; cpu_addr = 16'h2000; dma_we = 1'b0; dma_addr = 16'h3000;
        cpu_req = 1'b1; dma_req = 1'b1;
        nd = 0;
        for (int c = 0; c < 100 && nd < 2; c++) begin
            @(negedge clk24);
            if (dma_ack) nd++;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        if (nd < 2) chk("both_timeout", nd, 2);
        // fetch_en dropped at ph 2 of a full frame: takes effect at ph 8.
        do_reset();
        wait_ph(31);
        wait_ph(2);
        sram_din = 8'h3C;
        for (int i = 0; i < 8; i++) push(1, (7 + 4 * i) % 32, 16'h4000, 1'b1, 8'h3C);
        fetch_en = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h4000; cpu_req = 1'b1;
        @(negedge clk24);
        chk("fetch_hold_vs", {video_slice, sram_oe_n, sram_addr}, {1'b1, 1'b0, video_addr});
        na = 0; past8 = 1'b0;
        for (int c = 0; c < 80 && na < 8; c++) begin
            @(negedge clk24);
            if (mph == 5'd8) past8 = 1'b1;
            if (past8) chk("fetch_off_vs", video_slice, 0);
            if (cpu_ack) na++;
        end
        cpu_req = 1'b0; fetch_en = 1'b1;
        if (na < 8) chk("fetch_off_timeout", na, 8);
        // Reset at ph 5 during a write: strobes drop, access lost, phase restarts.
        do_reset();
        wait_ph(2);
        cpu_we = 1'b1; cpu_addr = 16'h9000; cpu_wdata = 8'h55; cpu_req = 1'b1;
        wait_ph(5);
        chk("mid_wr_we_n", sram_we_n, 0);
        reset = 1'b1;
        @(negedge clk24);
        chk("rst_wr_strobes", {sram_we_n, sram_dq_oe, cpu_ack}, 3'b100);
        cpu_req = 1'b0;
        @(negedge clk24);
        reset = 1'b0;
        @(negedge clk24);
        chk("rst_ph_restart", {ce12, ce6, ce6x}, 3'b101);
        repeat (12) @(negedge clk24);
        chk("pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_slice_arbiter.md
# sram_slice_arbiter

Time-slice scheduler and SRAM arbiter for the video/CPU memory subsystem. It derives the clk24 clock enables (ce12, ce6, ce6x) and the video_slice/pipe_ab strobes that the video subsystem consumes. It multiplexes the single 8-bit SRAM between three users: the framebuffer fetch, the CPU, and a secondary DMA requester (disk/OSD loader). CPU and DMA accesses use a req/ack handshake and never disturb video timing.

## Interface
Parameters:
- STARVE_MAX, 3: number of consecutive lost DMA slots after which DMA wins the next slot.

Ports (one clock; reset is synchronous, active-high):
- clk24  in  1  system clock, 24 MHz
- reset  in  1  synchronous active-high reset
- fetch_en  in  1  1 = video slots belong to the framebuffer; 0 = video slots become CPU/DMA-eligible
- video_addr  in  16  framebuffer fetch address
- cpu_req, cpu_we  in  1  CPU request and write flag
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- dma_req, dma_we  in  1  DMA request and write flag
- dma_addr  in  16  DMA address
- dma_wdata  in  8  DMA write data
- dma_ack  out  1  one-cycle completion pulse
- rdata  out  8  read data latched for the last completed CPU/DMA read
- sram_addr  out  16  SRAM address
- sram_dout  out  8  SRAM write data
- sram_din  in  8  SRAM read data
- sram_dq_oe  out  1  drive the data bus
- sram_we_n, sram_oe_n  out  1  SRAM strobes, active low
- ce12, ce6, ce6x  out  1  clock enables
- video_slice, pipe_ab  out  1  video-slot and pipeline-half strobes

## Operation
- Phase counter ph[4:0] increments every clk24 and wraps 31→0. Slot position s = ph[2:0].
- Enables:
  - ce12 = (ph[0]==1).
  - ce6 = (ph[1:0]==3).
  - ce6x = (ph[1:0]==1).
  - pipe_ab = ph[3].
  - video_slice = fetch_en & (s<4).
- Video slot (s=0..3, fetch_en=1): sram_addr=video_addr, sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
- Access slot: s=4..7 always. s=0..3 also counts as an access slot when fetch_en=0, sampled at slot start. Within an access slot, let k = s−4 in the upper half, or k = s in the lower half.
- Arbitration at k=0: cpu_req and dma_req are sampled; a winner is registered with its addr/we/wdata.
  - CPU wins by default.
  - DMA wins if cpu_req=0, or if starve==STARVE_MAX.
  - starve (2-bit) increments, saturating, for each slot in which DMA requested and lost. It clears on a DMA grant.
  - No request means an idle slot: strobes stay inactive and the address holds the last value.
- Read: sram_oe_n=0 for k=0..3. rdata<=sram_din at k=3. The winner's ack pulses at k=3.
- Write: sram_dq_oe=1 and sram_dout=wdata for k=0..3. sram_we_n=0 for k=1..2 only, which gives address/data setup and hold margins. Ack pulses at k=3.
- Requests are sampled only at k=0.
  - A requester holds req and its fields stable until its ack.
  - If req is still high in the slot after the ack, it is a new access.
  - A requester whose request lost keeps waiting; there is no timeout.
- fetch_en changes take effect only at an s=0 boundary. A change in mid-slot is ignored until the next s=0.

## Timing
- Reset state: ph=0, starve=0, no winner. Outputs are ce12=ce6=ce6x=0, video_slice=0, pipe_ab=0, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, cpu_ack=dma_ack=0, rdata=0, sram_addr=0, sram_dout=0.
- The first cycle after reset deassertion is ph=0.
- All outputs are registered. Each output holds its phase value in the same cycle the internal ph holds that phase, so the next-state decode happens one cycle ahead.
- Latency from the k=0 sample to ack is 3 cycles. The worst-case CPU wait is 8 cycles with fetch_en=1, plus one slot each time DMA starvation forces a DMA win.
- Reset mid-write: sram_we_n=1 and sram_dq_oe=0 in the cycle after reset is sampled; no ack is issued and the access is lost.
- Simultaneous ack and new req at k=0 of the next slot: the request is treated as new.

## Structure
- A shared package holds:
  - the slot position constants: VID_FIRST=0, ACC_FIRST=4, WE_START=1, WE_END=2, ACK_K=3;
  - the requester encoding: NONE, CPU, DMA.
- Sub-module slice_timer contains the ph counter and registered enable decode (ce12, ce6, ce6x, pipe_ab, video_slice, s, slot-start flags).
- The arbiter/strobe FSM sits in the top level. Its states are IDLE, VID, ACC_RD, ACC_WR, chosen at each slot start.

## Test plan
- Reset released, no requests, fetch_en=1: ce12 period 2, ce6 period 4 with ce6x 2 cycles offset, pipe_ab period 16; sram_oe_n low at ph 0..3, 8..11, 16..19 and 24..27; no acks.
- CPU read of 0x1234 issued at ph=2: sram_addr=0x1234 at ph 4..7; cpu_ack at ph=7; rdata equals sram_din at ph 7.
- CPU write 0xA5 to 0x8000: sram_dq_oe=1 at ph 4..7, sram_we_n=0 only at ph 5..6, sram_dout=0xA5, cpu_ack at ph 7; a video slot follows at ph 8 unaffected.
- CPU and DMA both held requesting continuously: grants go CPU, CPU, CPU, DMA, then repeat; dma_ack on every 4th access slot and starve returns to 0 after each DMA grant.
- fetch_en=0 with CPU requesting continuously: acks at ph 3, 7, 11, …, and video_slice stays 0. Deasserting fetch_en at ph=2 has no effect until ph=8.
- Reset asserted at ph=5 during a write: sram_we_n=1 on the next cycle, no cpu_ack, and ph=0 on the first cycle after reset.
